// File: rtl/axis_pkg.sv
// axis_pkg: shared defaults, address-width helper and FIFO entry layout for axis_s_fifo.
package axis_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 8;
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction
    typedef struct packed {
        logic                      last;
        logic [DATA_WIDTH_DEF-1:0] data;
    } entry_t;
endpackage

// File: rtl/axis_fifo_mem.sv
// axis_fifo_mem: DEPTH x W register array with one write port and an asynchronous read port.
module axis_fifo_mem
    import axis_pkg::*;
#(
    parameter int W      = DATA_WIDTH_DEF + 1,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [W-1:0]      wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [W-1:0]      rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/axis_s_fifo.sv
// axis_s_fifo: AXI-Stream slave with a DEPTH-entry first-word-fall-through FIFO and packet tracking.
// Define AXIS_S_FIFO_STORE_FWD_EN to hold the head until a whole packet is stored.
module axis_s_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       ready,
    input  logic                       tvalid,
    output logic                       tready,
    input  logic [DATA_WIDTH-1:0]      tdata,
    input  logic                       tlast,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       finish,
    output logic [CNT_WIDTH-1:0]       pkt_count,
    output logic                       pkt_err
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int LW     = ADDR_W + 1;
    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } ent_t;
    logic [ADDR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]        lvl_q, lvl_d;
    logic                 fin_q, fin_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 full, empty, push, pop, head_ok;
    ent_t                 wr_ent, rd_ent;

    axis_fifo_mem #(.W(DATA_WIDTH + 1), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk    (aclk),
        .we_i   (push),
        .waddr_i(wr_q),
        .wdata_i(wr_ent),
        .raddr_i(rd_q),
        .rdata_o(rd_ent)
    );

    assign full      = lvl_q == LW'(DEPTH);
    assign empty     = lvl_q == '0;
    assign tready    = ready && !full && !areset;
    assign push      = tvalid && tready;
    assign out_valid = !empty && head_ok;
    assign pop       = out_valid && out_ready;
    assign wr_ent    = ent_t'{last: tlast, data: tdata};
    assign out_data  = out_valid ? rd_ent.data : '0;
    assign out_last  = out_valid && rd_ent.last;
    assign level     = lvl_q;
    assign finish    = fin_q;
    assign pkt_count = cnt_q;

    always_comb begin
        wr_d  = push ? wr_q + ADDR_W'(1) : wr_q;
        rd_d  = pop ? rd_q + ADDR_W'(1) : rd_q;
        lvl_d = lvl_q + LW'(push) - LW'(pop);
        fin_d = push && tlast;
        cnt_d = cnt_q + CNT_WIDTH'(fin_d);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
            fin_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
            fin_q <= fin_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef AXIS_S_FIFO_STORE_FWD_EN
    logic [LW-1:0] cpl_q, cpl_d;
    logic          rel_q, rel_d, err_q, err_d, stuck;
    // A full FIFO holding no tlast can never complete: flag it and drain cut-through.
    always_comb begin
        stuck = full && cpl_q == '0;
        cpl_d = cpl_q + LW'(push && tlast) - LW'(pop && rd_ent.last);
        rel_d = stuck ? 1'b1 : (pop && rd_ent.last) ? 1'b0 : rel_q;
        err_d = err_q || stuck;
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            cpl_q <= '0;
            rel_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cpl_q <= cpl_d;
            rel_q <= rel_d;
            err_q <= err_d;
        end
    end
    assign head_ok = cpl_q != '0 || rel_q;
    assign pkt_err = err_q;
`else
    assign head_ok = 1'b1;
    assign pkt_err = 1'b0;
`endif
endmodule

// File: tb/tb_axis_s_fifo.sv
// tb_axis_s_fifo: randomized and directed checks of axis_s_fifo against a queue-based model.
module tb_axis_s_fifo;
    localparam int DW = 32, DEPTH = 8, CW = 16, LW = 4;
    logic aclk = 0, areset = 1, ready = 0, tvalid = 0, tlast = 0, out_ready = 0;
    logic tready, out_valid, out_last, finish, pkt_err;
    logic [DW-1:0] tdata = 0, out_data;
    logic [LW-1:0] level;
    logic [CW-1:0] pkt_count;

    always #5 aclk = ~aclk;

    axis_s_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .aclk(aclk), .areset(areset), .ready(ready), .tvalid(tvalid), .tready(tready),
        .tdata(tdata), .tlast(tlast), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .level(level), .finish(finish),
        .pkt_count(pkt_count), .pkt_err(pkt_err)
    );

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;
    beat_t q[$];
    logic m_fin = 0, m_rel = 0, m_err = 0;
    logic [CW-1:0] m_cnt = 0;
    int n_chk = 0, n_fail = 0;
    bit did_push;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit has_last();
        foreach (q[i]) if (q[i].last) return 1;
        return 0;
    endfunction

    function automatic bit exp_ov();
`ifdef AXIS_S_FIFO_STORE_FWD_EN
        return q.size() > 0 && (has_last() || m_rel);
`else
        return q.size() > 0;
`endif
    endfunction

    task automatic step();
        bit xt, ov, push, pop, hl;
        logic [DW-1:0] hd;
`ifdef AXIS_S_FIFO_STORE_FWD_EN
        bit popl, stuck;
`endif
        @(negedge aclk);
        ov = exp_ov();
        xt = !areset && ready && q.size() < DEPTH;
        hd = ov ? q[0].data : '0;
        hl = ov && q[0].last;
        chk("tready", tready, xt);
        chk("out_valid", out_valid, ov);
        chk("out_data", out_data, hd);
        chk("out_last", out_last, hl);
        chk("level", level, q.size());
        chk("finish", finish, m_fin);
        chk("pkt_count", pkt_count, m_cnt);
        chk("pkt_err", pkt_err, m_err);
        push = tvalid && xt;
        pop  = ov && out_ready;
`ifdef AXIS_S_FIFO_STORE_FWD_EN
        popl  = pop && hl;
        stuck = q.size() == DEPTH && !has_last();
`endif
        @(posedge aclk);
        if (areset) begin
            q.delete();
            m_fin = 0; m_cnt = 0; m_rel = 0; m_err = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(beat_t'{last: tlast, data: tdata});
            m_fin = push && tlast;
            if (m_fin) m_cnt++;
`ifdef AXIS_S_FIFO_STORE_FWD_EN
            m_rel = stuck ? 1'b1 : popl ? 1'b0 : m_rel;
            m_err = m_err | stuck;
`endif
        end
        did_push = push && !areset;
        #1;
    endtask

    task automatic drv(input bit r, input bit v, input logic [DW-1:0] d, input bit l, input bit o);
        ready = r; tvalid = v; tdata = d; tlast = l; out_ready = o;
        step();
    endtask

    initial begin
        int sent;
        repeat (2) @(posedge aclk);
        #1;
        drv(0, 0, 0, 0, 0);
        areset = 0;
        // single beat
        drv(1, 1, 32'hAAAABBBB, 1, 1);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 32'hAAAABBBB);
        chk("single_last", out_last, 1);
        chk("single_finish", finish, 1);
        chk("single_count", pkt_count, 1);
        drv(1, 0, 0, 0, 1);
        chk("single_finish_once", finish, 0);
        chk("single_empty", level, 0);
        // fill to full, pop once, drain
        for (int i = 0; i < 8; i++) drv(1, 1, i, i == 7, 0);
        chk("fill_level", level, 8);
        chk("fill_tready", tready, 0);
        chk("fill_head", out_data, 0);
        drv(1, 0, 0, 0, 1);
        chk("fill_tready_back", tready, 1);
        chk("fill_head2", out_data, 1);
        for (int i = 0; i < 8; i++) drv(1, 0, 0, 0, 1);
        chk("drain_level", level, 0);
        // simultaneous push and pop at level 4
        for (int i = 0; i < 4; i++) drv(1, 1, 100 + i, 1, 0);
        for (int i = 0; i < 20; i++) drv(1, 1, 200 + i, 1, 1);
        chk("simul_level", level, 4);
        for (int i = 0; i < 5; i++) drv(1, 0, 0, 0, 1);
        // local gate
        for (int i = 0; i < 3; i++) drv(0, 1, 32'h55, 1, 0);
        chk("gate_level", level, 0);
        drv(1, 1, 32'h55, 1, 0);
        chk("gate_accept", level, 1);
        drv(1, 0, 0, 0, 1);
        // reset mid-packet
        for (int i = 0; i < 5; i++) drv(1, 1, 300 + i, 0, 0);
        chk("rst_pre_level", level, 5);
        areset = 1;
        drv(1, 0, 0, 0, 0);
        areset = 0;
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_finish", finish, 0);
        drv(1, 1, 32'hCCCCDDDD, 1, 1);
        chk("rst_new_data", out_data, 32'hCCCCDDDD);
        drv(1, 0, 0, 0, 1);
`ifdef AXIS_S_FIFO_STORE_FWD_EN
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 400 + i, i == 2, 1);
            if (i < 2) chk("sf_hold", out_valid, 0);
        end
        chk("sf_release", out_valid, 1);
        repeat (4) drv(1, 0, 0, 0, 1);
        sent = 0;
        for (int c = 0; c < 80 && !(sent == 10 && q.size() == 0); c++) begin
            drv(1, sent < 10, 500 + sent, sent == 9, 1);
            if (did_push) sent++;
        end
        chk("sf_sent", sent, 10);
        chk("sf_err", pkt_err, 1);
        chk("sf_drained", level, 0);
`endif
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            areset = ($urandom_range(0, 199) == 0);
            drv($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6);
        end
        areset = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
